reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file, the successor to the single-write/dual-read register file in the single-cycle datapath. Provides NUM_RD asynchronous read ports, two synchronous write ports with a fixed priority, and same-cycle write-to-read bypass. It clears its storage sequentially, one entry per cycle, after reset or on request. It targets the upcoming pipelined and dual-issue cores, where reset cannot fan out to every storage bit.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 3, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 is hardwired zero (reads 0, writes dropped); 0 = entry 0 is an ordinary register

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr_req  in  1  request a full clear; accepted only in RUN
- ready  out  1  high when in RUN and accepting writes; reads are valid
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]

## Operation
- FSM has two states: CLEAR and RUN, plus clr_ptr (ADDR_W+1 bits).
- Reset (rst_n=0 at an edge):
  - state <= CLEAR, clr_ptr <= 0, ready <= 0.
  - Storage is not written while rst_n=0.
- CLEAR, rst_n=1:
  - At each edge, write 0 to entry clr_ptr[ADDR_W-1:0], then clr_ptr++.
  - On the edge that clears entry DEPTH-1: state <= RUN, ready <= 1.
- RUN:
  - Write ports are live.
  - clr_req=1 at an edge: state <= CLEAR, clr_ptr <= 0, ready <= 0. Any write presented in that same cycle is dropped.
- Writes (RUN only):
  - A port writes when we is high and the address is not 0 (or ZERO_REG=0).
  - If wa0==wa1 and both are enabled, wd1 is stored and wd0 is discarded.
  - Writes are ignored in CLEAR.
- Reads (combinational, per port i):
  - ready=0: rd_i = 0.
  - ZERO_REG=1 and ra_i==0: rd_i = 0.
  - Otherwise priority: port-1 write to ra_i this cycle returns wd1; else port-0 write to ra_i returns wd0; else the stored value.
  - Bypass applies only to writes that will actually commit (RUN, we high, address not a dropped zero-register write, clr_req low).
- Boundaries:
  - Reset asserted mid-clear restarts the clear from entry 0.
  - clr_req is ignored while in CLEAR.
  - clr_ptr does not wrap; it is reset on every entry to CLEAR.

## Timing
- Write latency: 1 edge into storage; 0 cycles to the read ports via bypass.
- Read latency: combinational from ra, and from we/wa/wd via bypass.
- ready stays low from the first edge sampling rst_n=0 until the DEPTH-th edge with rst_n=1. For DEPTH=32, ready rises after the 32nd such edge.
- clr_req accepted at edge k: ready is low after edge k and high again after edge k+DEPTH.
- Reset values:
  - ready = 0
  - rd = all zeros
  - storage contents are undefined until the clear completes.

## Structure
- Package reg_file_pkg:
  - state enum (RF_CLEAR, RF_RUN)
  - default DATA_W/ADDR_W/NUM_RD constants
  - a localparam function for DEPTH
- Sub-module rf_clear_ctrl holds the FSM, clr_ptr and ready, and outputs a clear-write strobe and address.
- reg_file_mp holds storage, write arbitration, and a generate loop over the NUM_RD read/bypass muxes.

## Test plan
- Reset then clear: hold rst_n=0 for 3 cycles, then release. ready rises exactly after the 32nd edge; all ports read 0 before and after.
- Basic write/read: we0=1, wa0=5, wd0=0xDEADBEEF; next cycle ra[0]=5 returns 0xDEADBEEF; ra[1]=0 returns 0.
- Dual-write conflict: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22. Same cycle, ra=7 bypass shows 0x22; next cycle the stored value is 0x22.
- Bypass and zero register:
  - we1=1, wa1=9, wd1=0xA5 with ra[2]=9 shows 0xA5 in the same cycle.
  - we0=1, wa0=0, wd0=0xFF leaves ra=0 reading 0 (ZERO_REG=1).
  - With ZERO_REG=0, the same write reads back 0xFF.
- Runtime clear: fill entries 1..31 with nonzero values, then pulse clr_req together with we0 to entry 3.
  - ready drops; the write is dropped; reads return 0.
  - After 32 edges, ready=1 and all entries read 0.
- Reset mid-clear: assert rst_n=0 at clr_ptr=10, then release. The full DEPTH-cycle clear restarts before ready rises.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
// Pure declarations: no logic, no latency, no flow control.
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 3;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear/run sequencer: sweeps one entry per cycle after reset or clr_req.
// Latency: DEPTH edges per sweep; clr_req is ignored while a sweep is running.
module rf_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  rf_state_t       state;
  rf_state_t       state_nxt;
  logic [ADDR_W:0] clr_ptr;
  logic [ADDR_W:0] ptr_nxt;
  logic            ready_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
      ready   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    ready_nxt = ready;
    if (state == RF_CLEAR) begin
      ptr_nxt = clr_ptr + 1'b1;
      if (clr_ptr == LAST_PTR) begin
        state_nxt = RF_RUN;
        ready_nxt = 1'b1;
      end
    end else if (clr_req) begin
      state_nxt = RF_CLEAR;
      ptr_nxt   = '0;
      ready_nxt = 1'b0;
    end
  end

  // Gated by rst_n so a held reset never touches storage.
  assign clr_we   = rst_n && (state == RF_CLEAR);
  assign clr_addr = clr_ptr[ADDR_W-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async reads, two sync writes (port 1 wins), same-cycle bypass.
// Latency: 1 edge to storage, 0 to reads; writes are dropped while ready is low.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              zero_ok0;
  logic              zero_ok1;
  logic              commit0;
  logic              commit1;

  logic [DATA_W-1:0] mem [DEPTH];

  rf_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign zero_ok0 = (ZERO_REG == 0) || (wa0 != '0);
  assign zero_ok1 = (ZERO_REG == 0) || (wa1 != '0);

  // A commit qualifier shared by storage and bypass keeps the two from disagreeing.
  assign commit0 = ready && rst_n && !clr_req && we0 && zero_ok0;
  assign commit1 = ready && rst_n && !clr_req && we1 && zero_ok1;

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (commit0) mem[wa0] <= wd0;
      if (commit1) mem[wa1] <= wd1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic [DATA_W-1:0] rd_i;

    assign ra_i = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_i = '0;
      if (ready && !((ZERO_REG != 0) && (ra_i == '0))) begin
        if (commit1 && (wa1 == ra_i)) begin
          rd_i = wd1;
        end else if (commit0 && (wa0 == ra_i)) begin
          rd_i = wd0;
        end else begin
          rd_i = mem[ra_i];
        end
      end
    end

    assign rd[i*DATA_W +: DATA_W] = rd_i;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: one zero-register and one plain instance share stimulus.
// Expected read data is queued at drive time and popped against the DUT outputs.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           clr_req;
  logic           we0;
  logic           we1;
  logic [AW-1:0]  wa0;
  logic [AW-1:0]  wa1;
  logic [DW-1:0]  wd0;
  logic [DW-1:0]  wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd_z;
  logic [NR*DW-1:0] rd_nz;
  logic           ready_z;
  logic           ready_nz;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_z),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_z)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_nz),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_nz)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic          nz;
    logic [1:0]    port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: index 0 = zero-register instance, 1 = plain instance.
  logic [DW-1:0] m_mem [2][DEPTH];
  bit m_ready = 1'b0;
  int m_ptr   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int nz, input int p);
    logic [AW-1:0] a;
    bit zr;
    bit c0;
    bit c1;
    a  = ra[p*AW +: AW];
    zr = (nz == 0);
    c0 = m_ready && rst_n && !clr_req && we0 && (!zr || wa0 != 0);
    c1 = m_ready && rst_n && !clr_req && we1 && (!zr || wa1 != 0);
    if (!m_ready) return '0;
    if (zr && a == 0) return '0;
    if (c1 && wa1 == a) return wd1;
    if (c0 && wa0 == a) return wd0;
    return m_mem[nz][a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_ready = 1'b0;
      m_ptr   = 0;
    end else if (!m_ready) begin
      for (int z = 0; z < 2; z++) m_mem[z][m_ptr] = '0;
      m_ptr++;
      if (m_ptr == DEPTH) m_ready = 1'b1;
    end else if (clr_req) begin
      m_ready = 1'b0;
      m_ptr   = 0;
    end else begin
      for (int z = 0; z < 2; z++) begin
        if (we0 && (z == 1 || wa0 != 0)) m_mem[z][wa0] = wd0;
        if (we1 && (z == 1 || wa1 != 0)) m_mem[z][wa1] = wd1;
      end
    end
  endtask

  // One cycle: push expectations, compare at negedge, advance model at posedge.
  task automatic step();
    exp_t e;
    logic [DW-1:0] got;
    @(negedge clk);
    for (int z = 0; z < 2; z++) begin
      for (int p = 0; p < NR; p++) begin
        e.nz   = z[0];
        e.port = p[1:0];
        e.val  = exp_rd(z, p);
        sb_q.push_back(e);
      end
    end
    chk("ready_z",  {31'b0, ready_z},  {31'b0, m_ready});
    chk("ready_nz", {31'b0, ready_nz}, {31'b0, m_ready});
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = e.nz ? rd_nz[e.port*DW +: DW] : rd_z[e.port*DW +: DW];
      chk($sformatf("rd%0d_%s", e.port, e.nz ? "nz" : "z"), got, e.val);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_ra(input int p, input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_z && n < 100) begin
      step();
      n++;
    end
    chk(tag, DW'(n), DW'(DEPTH));
  endtask

  task automatic sweep();
    idle();
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int p = 0; p < NR; p++) set_ra(p, (a + p) % DEPTH);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
    for (int z = 0; z < 2; z++)
      for (int a = 0; a < DEPTH; a++) m_mem[z][a] = '0;

    // Reset for 3 edges, then the clear sweep.
    @(posedge clk); model_edge(); #1;
    step(); step();
    rst_n = 1'b1;
    wait_ready("clr_len_rst");
    sweep();

    // Basic write/read.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; set_ra(0, 5); set_ra(1, 0);
    step();
    idle();
    #1 chk("basic_rd", rd_z[0 +: DW], 32'hDEADBEEF);
    chk("basic_r0", rd_z[DW +: DW], 32'h0);
    step();

    // Dual-write collision.
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22;
    set_ra(0, 7);
    #1 chk("conf_byp", rd_z[0 +: DW], 32'h22);
    step();
    idle();
    #1 chk("conf_store", rd_z[0 +: DW], 32'h22);
    step();

    // Bypass on port 2, zero-register behaviour on both instances.
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hA5; set_ra(2, 9);
    #1 chk("byp_p2", rd_z[2*DW +: DW], 32'hA5);
    step();
    idle();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFF; ra = '0;
    #1 chk("zero_byp_z", rd_z[0 +: DW], 32'h0);
    chk("zero_byp_nz", rd_nz[0 +: DW], 32'hFF);
    step();
    idle();
    #1 chk("zero_st_z", rd_z[0 +: DW], 32'h0);
    chk("zero_st_nz", rd_nz[0 +: DW], 32'hFF);
    step();

    // Runtime clear with a colliding write that must be dropped.
    for (int a = 1; a < DEPTH; a++) begin
      we0 = 1'b1; wa0 = AW'(a); wd0 = 32'h01010101 * a + 32'h100;
      step();
    end
    sweep();
    clr_req = 1'b1; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5555; set_ra(0, 3);
    step();
    idle();
    #1 chk("rtclr_rdy", {31'b0, ready_z}, 32'h0);
    chk("rtclr_rd", rd_z[0 +: DW], 32'h0);
    wait_ready("clr_len_rt");
    sweep();
    set_ra(0, 3);
    #1 chk("rtclr_drop", rd_z[0 +: DW], 32'h0);

    // Reset during a clear sweep restarts from entry 0; clr_req is ignored mid-sweep.
    clr_req = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready("clr_len_midrst");
    sweep();

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = AW'($urandom); wa1 = AW'($urandom);
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      wd0 = $urandom; wd1 = $urandom;
      ra  = (NR*AW)'($urandom);
      clr_req = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 40 && !ready_z; i++) step();
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
